// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// datapath mux selects and the control-word bundle.
package cpu_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch_type;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps the current FSM state to the datapath control word.
module control_decode
    import cpu_pkg::*;
(
    input  state_t i_state,
    input  logic   i_branch_ne,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = ALUB_FOUR;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = ALUB_IMM_SH2;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_I_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a   = 1'b1;
                o_ctrl.alu_src_b   = ALUB_REG;
                o_ctrl.alu_op      = ALUOP_SUB;
                o_ctrl.branch_type = 1'b1;
                o_ctrl.branch_ne   = i_branch_ne;
                o_ctrl.pc_source   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM: state register, opcode latch, sticky
// illegal-opcode flag; outputs are decoded from registered state only.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    output logic               PCWrite,
    output logic               BranchType,
    output logic               BranchNe,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_run;
    logic            r_illegal;
    logic [OP_W-1:0] r_opcode;
    logic            w_illegal_decode;
    ctrl_t           w_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // r_run stays low from reset until the first edge after release, holding FETCH idle
    always_comb begin
        w_next_state     = r_state;
        w_illegal_decode = 1'b0;
        if (!r_run) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  w_next_state = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:   w_next_state = S_MEM_ADDR;
                        OP_RTYPE:       w_next_state = S_R_EXEC;
                        OP_ADDI:        w_next_state = S_I_EXEC;
                        OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                        OP_J:           w_next_state = S_JUMP;
                        default: begin
                            w_next_state     = S_FETCH;
                            w_illegal_decode = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: w_next_state = (r_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: w_next_state = S_MEM_WB;
                S_R_EXEC:   w_next_state = S_R_WB;
                S_I_EXEC:   w_next_state = S_I_WB;
                default:    w_next_state = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run     <= 1'b0;
            r_illegal <= 1'b0;
            r_opcode  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_illegal_decode) r_illegal <= 1'b1;
            if (r_state == S_DECODE) r_opcode <= opcode;
        end
    end

    control_decode u_decode (
        .i_state     (r_state),
        .i_branch_ne (r_opcode[0]),
        .o_ctrl      (w_ctrl)
    );

    // Fetch strobes are suppressed until the FSM has been released from reset
    always_comb begin
        PCWrite    = w_ctrl.pc_write & r_run;
        BranchType = w_ctrl.branch_type;
        BranchNe   = w_ctrl.branch_ne;
        PCSource   = w_ctrl.pc_source;
        IorD       = w_ctrl.iord;
        MemRead    = w_ctrl.mem_read & r_run;
        MemWrite   = w_ctrl.mem_write;
        IRWrite    = w_ctrl.ir_write & r_run;
        ALUSrcA    = w_ctrl.alu_src_a;
        ALUSrcB    = w_ctrl.alu_src_b;
        ALUOp      = w_ctrl.alu_op;
        RegDst     = w_ctrl.reg_dst;
        MemtoReg   = w_ctrl.mem_to_reg;
        RegWrite   = w_ctrl.reg_write;
        illegal_op = r_illegal;
        state      = STATE_W'(r_state);
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-stream bench for multicycle_control with an
// instruction-level reference model and per-cycle output comparison.
module tb_multicycle_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       PCWrite, BranchType, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;

    int     checks = 0;
    int     errors = 0;
    state_t exp_state = S_FETCH;
    bit     exp_run = 1'b0;
    bit     exp_ne = 1'b0;
    bit     exp_ill = 1'b0;
    bit     ill_pend = 1'b0;
    bit     chk_en = 1'b0;
    bit     lit_fetch = 1'b0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .PCWrite    (PCWrite),
        .BranchType (BranchType),
        .BranchNe   (BranchNe),
        .PCSource   (PCSource),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .state      (state)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: the state walk each opcode takes, FETCH first
    task automatic get_seq(input logic [5:0] op, output state_t s[5], output int len, output bit ill);
        s   = '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH};
        ill = 1'b0;
        case (op)
            OP_LW:          begin s[2] = S_MEM_ADDR; s[3] = S_MEM_READ;  s[4] = S_MEM_WB; len = 5; end
            OP_SW:          begin s[2] = S_MEM_ADDR; s[3] = S_MEM_WRITE; len = 4; end
            OP_RTYPE:       begin s[2] = S_R_EXEC;   s[3] = S_R_WB;      len = 4; end
            OP_ADDI:        begin s[2] = S_I_EXEC;   s[3] = S_I_WB;      len = 4; end
            OP_BEQ, OP_BNE: begin s[2] = S_BRANCH;   len = 3; end
            OP_J:           begin s[2] = S_JUMP;     len = 3; end
            default:        begin len = 2; ill = 1'b1; end
        endcase
    endtask

    // Per-cycle comparison: each output expressed as the set of states that assert it
    always @(negedge clk) begin
        if (chk_en) begin
            state_t s;
            bit     f;
            s = exp_state;
            f = (s == S_FETCH);
            chk("state",      state,            4'(s));
            chk("illegal_op", 4'(illegal_op),   4'(exp_ill));
            chk("PCWrite",    4'(PCWrite),      4'(exp_run && (f || s == S_JUMP)));
            chk("BranchType", 4'(BranchType),   4'(s == S_BRANCH));
            chk("BranchNe",   4'(BranchNe),     4'(s == S_BRANCH && exp_ne));
            chk("PCSource",   4'(PCSource),     (s == S_BRANCH) ? 4'd1 : (s == S_JUMP) ? 4'd2 : 4'd0);
            chk("IorD",       4'(IorD),         4'(s == S_MEM_READ || s == S_MEM_WRITE));
            chk("MemRead",    4'(MemRead),      4'((f && exp_run) || s == S_MEM_READ));
            chk("MemWrite",   4'(MemWrite),     4'(s == S_MEM_WRITE));
            chk("IRWrite",    4'(IRWrite),      4'(f && exp_run));
            chk("ALUSrcA",    4'(ALUSrcA),      4'(s == S_MEM_ADDR || s == S_R_EXEC || s == S_I_EXEC || s == S_BRANCH));
            chk("ALUSrcB",    4'(ALUSrcB),      f ? 4'd1 : (s == S_DECODE) ? 4'd3 :
                                                (s == S_MEM_ADDR || s == S_I_EXEC) ? 4'd2 : 4'd0);
            chk("ALUOp",      4'(ALUOp),        (s == S_R_EXEC) ? 4'd2 : (s == S_BRANCH) ? 4'd1 : 4'd0);
            chk("RegDst",     4'(RegDst),       4'(s == S_R_WB));
            chk("MemtoReg",   4'(MemtoReg),     4'(s == S_MEM_WB));
            chk("RegWrite",   4'(RegWrite),     4'(s == S_MEM_WB || s == S_R_WB || s == S_I_WB));
            chk("pcwrite_branch_excl", 4'(PCWrite & BranchType), 4'd0);
        end
    end

    // Called just after an active edge: async reset mid-cycle, release mid-cycle later
    task automatic mid_reset();
        #1 reset = 1'b1;
        exp_state = S_FETCH;
        exp_run   = 1'b0;
        exp_ill   = 1'b0;
        ill_pend  = 1'b0;
        #1;
        chk("rst_async_state",   state,        4'd0);
        chk("rst_async_memread", 4'(MemRead),  4'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_release_memread", 4'(MemRead), 4'd0);
        lit_fetch = 1'b1;
    endtask

    // scr_mode: 0 hold opcode, 1 randomize opcode after DECODE, 2 force scr_val after DECODE
    task automatic run_instr(input logic [5:0] op, input int scr_mode, input logic [5:0] scr_val, input int rst_at);
        state_t seq[5];
        int     len;
        bit     ill;
        get_seq(op, seq, len, ill);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (ill_pend) begin
                exp_ill  = 1'b1;
                ill_pend = 1'b0;
            end
            exp_run   = 1'b1;
            exp_state = seq[k];
            exp_ne    = op[0];
            if (k == 0) begin
                opcode = op;
                if (lit_fetch) begin
                    chk("fetch_after_release_memread", 4'(MemRead), 4'd1);
                    chk("fetch_after_release_irwrite", 4'(IRWrite), 4'd1);
                    lit_fetch = 1'b0;
                end
            end
            if (k >= 2 && scr_mode == 1) opcode = 6'($urandom);
            if (k == 2 && scr_mode == 2) opcode = scr_val;
            if (k == rst_at) begin
                mid_reset();
                return;
            end
        end
        if (ill) ill_pend = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        int         rst_at;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_J, 6'd0};

        #1 reset = 1'b1;
        #1;
        chk("reset_state",    state,          4'd0);
        chk("reset_illegal",  4'(illegal_op), 4'd0);
        chk("reset_pcwrite",  4'(PCWrite),    4'd0);
        chk("reset_alusrcb",  4'(ALUSrcB),    4'd1);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        lit_fetch = 1'b1;

        run_instr(OP_LW, 0, 6'd0, -1);
        chk("lw_c5_state",    state,         4'd4);
        chk("lw_c5_regwrite", 4'(RegWrite),  4'd1);
        chk("lw_c5_memtoreg", 4'(MemtoReg),  4'd1);

        run_instr(OP_BNE, 0, 6'd0, -1);
        chk("bne_c3_state",      state,           4'd10);
        chk("bne_c3_branchtype", 4'(BranchType),  4'd1);
        chk("bne_c3_branchne",   4'(BranchNe),    4'd1);
        chk("bne_c3_pcsource",   4'(PCSource),    4'd1);
        chk("bne_c3_pcwrite",    4'(PCWrite),     4'd0);
        chk("bne_c3_aluop",      4'(ALUOp),       4'd1);

        run_instr(OP_J, 0, 6'd0, -1);
        chk("j_c3_pcwrite",  4'(PCWrite),  4'd1);
        chk("j_c3_pcsource", 4'(PCSource), 4'd2);

        run_instr(6'b111111, 0, 6'd0, -1);
        run_instr(OP_RTYPE, 2, OP_SW, -1);
        chk("r_after_illegal_flag", 4'(illegal_op), 4'd1);
        chk("r_scrambled_regwrite", 4'(RegWrite),   4'd1);
        chk("r_scrambled_regdst",   4'(RegDst),     4'd1);
        chk("r_scrambled_memwrite", 4'(MemWrite),   4'd0);

        run_instr(OP_LW, 0, 6'd0, 3);
        chk("after_reset_illegal", 4'(illegal_op), 4'd0);
        run_instr(OP_BEQ, 1, 6'd0, -1);
        chk("beq_c3_branchne", 4'(BranchNe), 4'd0);

        repeat (300) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'd0 && $urandom_range(0, 1) == 1) op = 6'($urandom);
            rst_at = ($urandom_range(0, 30) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, 1, 6'd0, rst_at);
        end

        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; opcode encodings and state codes SHALL come from the shared package.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register, sampled in DECODE.
REQ-005 PCWrite  output  1  unconditional PC update enable.
REQ-006 BranchType  output  1  conditional-branch cycle; PC updates only if the external Branch condition is true.
REQ-007 BranchNe  output  1  comparator polarity: 0 = beq (equal), 1 = bne (not equal).
REQ-008 PCSource  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 IorD, MemRead, MemWrite, IRWrite  output  1 each  memory address select (0 = PC), read strobe, write strobe, IR load.
REQ-010 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-011 ALUSrcB  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
REQ-012 ALUOp  output  2  ALU operation: 00 add, 01 subtract, 10 use funct field.
REQ-013 RegDst, MemtoReg, RegWrite  output  1 each  write-register select (1 = rd), write-data select (1 = MDR), register-file write enable.
REQ-014 illegal_op  output  1  sticky flag, set when DECODE sees an unsupported opcode.
REQ-015 state  output  4  current state code, for debug.

Function
REQ-016 Moore FSM: every output SHALL be decoded from the registered state only; no opcode-to-output combinational path.
REQ-017 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-018 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; next state DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut); next state by opcode.
- lw 100011 or sw 101011 -> MEM_ADDR
- R-type 000000 -> R_EXEC
- addi 001000 -> I_EXEC
- beq 000100 or bne 000101 -> BRANCH
- j 000010 -> JUMP
- any other opcode -> FETCH, with illegal_op set
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEM_READ, sw -> MEM_WRITE.
REQ-021 MEM_READ: MemRead=1, IorD=1 -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-022 MEM_WRITE: MemWrite=1, IorD=1 -> FETCH.
REQ-023 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-024 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, BranchType=1, PCSource=01, PCWrite=0, BranchNe=opcode[0] -> FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10 -> FETCH.
REQ-027 Outputs not listed for a state SHALL be 0; PCWrite and BranchType SHALL never be asserted together.
REQ-028 Latency in cycles, FETCH inclusive: lw 5; sw, R-type, addi 4; beq, bne, j 3.
REQ-029 The opcode latched in DECODE SHALL be held in a register so later states are unaffected if the opcode input changes.

Reset
REQ-030 reset SHALL force state to FETCH and clear illegal_op and the latched opcode immediately, without waiting for clk, including mid-instruction.
REQ-031 While reset is high, outputs SHALL equal the FETCH decode, except PCWrite=0, IRWrite=0 and MemRead=0.
REQ-032 The first FETCH SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the opcode constants, the state enum/localparams, and the PCSource, ALUSrcB and ALUOp encodings.
REQ-034 Natural sub-module control_decode: pure combinational mapping from state to output bundle; the FSM register and next-state logic stay in multicycle_control.

Verification
REQ-035 Reset mid-MEM_READ -> state becomes FETCH asynchronously; MemRead=0 until release; FETCH outputs appear on the next edge after release.
REQ-036 opcode=100011 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-037 opcode=000101 -> BRANCH in cycle 3 with BranchType=1, BranchNe=1, PCSource=01, PCWrite=0, ALUOp=01.
REQ-038 opcode=000010 -> JUMP in cycle 3 with PCWrite=1 and PCSource=10; FETCH in cycle 4.
REQ-039 opcode=111111 -> DECODE, then FETCH; illegal_op=1 and remains set through a following R-type until reset.
REQ-040 opcode changed from 000000 to 101011 during R_EXEC -> R_WB still asserts RegWrite=1 and RegDst=1; no MemWrite pulse.
